// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : maze_pkg
//  Purpose : Shared maze geometry constants, table sentinel and feeder states.
//  Rev     : 1.0  initial release
// ============================================================================
package maze_pkg;

    localparam int         TILE      = 60;
    localparam int         ORIGIN_X  = 62;
    localparam int         ORIGIN_Y  = 108;
    localparam int         GRID_COLS = 15;
    localparam int         GRID_ROWS = 11;
    localparam int         TABLE_MAX = 256;
    localparam logic [7:0] SENTINEL  = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CONVERT = 3'd2,
        S_CHECK   = 3'd3,
        S_PRESENT = 3'd4
    } state_t;

    // Entry is {row[7:4], col[3:0]}; only cells on the playfield grid can be near.
    function automatic logic cell_in_grid(input logic [7:0] entry);
        return (int'(entry[3:0]) < GRID_COLS) && (int'(entry[7:4]) < GRID_ROWS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/maze_block_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module  : maze_block_feeder_if
//  Purpose : Hero-side bus of the block feeder (enable, hero pos, block pos).
//  Rev     : 1.0  initial release
// ============================================================================
interface maze_block_feeder_if;

    logic        enable;
    logic [11:0] hero_x_pos;
    logic [11:0] hero_y_pos;
    logic [11:0] block_x_pos;
    logic [11:0] block_y_pos;
    logic        block_valid;
    logic [7:0]  block_idx;
    logic        sweep_done;

    modport master (
        output enable, hero_x_pos, hero_y_pos,
        input  block_x_pos, block_y_pos, block_valid, block_idx, sweep_done
    );

    modport slave (
        input  enable, hero_x_pos, hero_y_pos,
        output block_x_pos, block_y_pos, block_valid, block_idx, sweep_done
    );

endinterface
`default_nettype wire

// File: rtl/maze_rom.sv
`default_nettype none
// ============================================================================
//  Module  : maze_rom
//  Purpose : Synchronous single-port block table, one-cycle registered read.
//  Rev     : 1.0  initial release
// ============================================================================
module maze_rom
    import maze_pkg::*;
#(
    parameter int                         DEPTH = 16,
    parameter logic [8*TABLE_MAX-1:0]     INIT  = {TABLE_MAX{SENTINEL}}
)(
    input  wire logic       clk,
    input  wire logic [7:0] addr,
    output logic      [7:0] data
);

    // Addresses past the table depth read as end-of-list.
    always_ff @(posedge clk) begin
        data <= (int'(addr) < DEPTH) ? INIT[{addr, 3'b000} +: 8] : SENTINEL;
    end

endmodule
`default_nettype wire

// File: rtl/maze_block_feeder.sv
`default_nettype none
// ============================================================================
//  Module  : maze_block_feeder
//  Purpose : Sweeps the maze table and presents blocks near the hero.
//  Rev     : 1.0  initial release
// ============================================================================
module maze_block_feeder #(
    parameter int                 NUM_BLOCKS   = 16,
    parameter int                 DWELL_CYCLES = 1024,
    parameter int                 TILE         = maze_pkg::TILE,
    parameter int                 ORIGIN_X     = maze_pkg::ORIGIN_X,
    parameter int                 ORIGIN_Y     = maze_pkg::ORIGIN_Y,
    parameter int                 NEAR_MARGIN  = 61,
    parameter logic [8*256-1:0]   ROM_INIT     = {256{maze_pkg::SENTINEL}}
)(
    input  wire logic          clk,
    input  wire logic          rst,
    maze_block_feeder_if.slave bus
);
    import maze_pkg::*;

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    state_t        r_state;
    logic [8:0]    r_idx;
    logic [11:0]   r_hx, r_hy, r_px, r_py;
    logic          r_cell_ok, r_sentinel, r_presented_any;
    logic [DW-1:0] r_dwell;
    logic [11:0]   r_bx, r_by;
    logic          r_bvalid, r_done;
    logic [7:0]    r_bidx;

    logic [7:0]         w_entry;
    logic [3:0]         w_col, w_row;
    logic [11:0]        w_col_off, w_row_off;
    logic signed [12:0] w_dx, w_dy;
    logic [12:0]        w_adx, w_ady;
    logic               w_near, w_end;

    maze_rom #(
        .DEPTH (NUM_BLOCKS),
        .INIT  (ROM_INIT)
    ) u_rom (
        .clk   (clk),
        .addr  (r_idx[7:0]),
        .data  (w_entry)
    );

    assign w_col = w_entry[3:0];
    assign w_row = w_entry[7:4];

    generate
        if (TILE == 60) begin : g_tile_shift
            // n*60 as (n<<6)-(n<<2)
            assign w_col_off = {2'b00, w_col, 6'b000000} - {6'b000000, w_col, 2'b00};
            assign w_row_off = {2'b00, w_row, 6'b000000} - {6'b000000, w_row, 2'b00};
        end else begin : g_tile_mul
            assign w_col_off = 12'(int'(w_col) * TILE);
            assign w_row_off = 12'(int'(w_row) * TILE);
        end
    endgenerate

    assign w_dx   = $signed({1'b0, r_hx}) - $signed({1'b0, r_px});
    assign w_dy   = $signed({1'b0, r_hy}) - $signed({1'b0, r_py});
    assign w_adx  = w_dx[12] ? -w_dx : w_dx;
    assign w_ady  = w_dy[12] ? -w_dy : w_dy;
    assign w_near = r_cell_ok && (w_adx <= 13'(NEAR_MARGIN)) && (w_ady <= 13'(NEAR_MARGIN));
    assign w_end  = r_sentinel || (r_idx == 9'(NUM_BLOCKS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_hx            <= '0;
            r_hy            <= '0;
            r_px            <= '0;
            r_py            <= '0;
            r_cell_ok       <= 1'b0;
            r_sentinel      <= 1'b0;
            r_presented_any <= 1'b0;
            r_dwell         <= '0;
            r_bx            <= '0;
            r_by            <= '0;
            r_bvalid        <= 1'b0;
            r_bidx          <= '0;
            r_done          <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.enable) begin
                        r_hx            <= bus.hero_x_pos;
                        r_hy            <= bus.hero_y_pos;
                        r_idx           <= '0;
                        r_presented_any <= 1'b0;
                        r_state         <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_CONVERT;
                S_CONVERT: begin
                    r_px       <= 12'(ORIGIN_X) + w_col_off;
                    r_py       <= 12'(ORIGIN_Y) + w_row_off;
                    r_cell_ok  <= cell_in_grid(w_entry);
                    r_sentinel <= (w_entry == SENTINEL);
                    r_state    <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_end) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                        // Park off the playfield when the sweep found nothing.
                        if (!r_presented_any) begin
                            r_bx     <= '0;
                            r_by     <= '0;
                            r_bvalid <= 1'b0;
                            r_bidx   <= '0;
                        end
                    end else if (w_near) begin
                        r_bx            <= r_px;
                        r_by            <= r_py;
                        r_bvalid        <= 1'b1;
                        r_bidx          <= r_idx[7:0];
                        r_presented_any <= 1'b1;
                        r_dwell         <= '0;
                        r_state         <= S_PRESENT;
                    end else begin
                        r_idx   <= r_idx + 9'd1;
                        r_state <= S_FETCH;
                    end
                end
                S_PRESENT: begin
                    if (r_dwell == DW'(DWELL_CYCLES - 1)) begin
                        r_idx   <= r_idx + 9'd1;
                        r_state <= S_FETCH;
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.block_x_pos = r_bx;
    assign bus.block_y_pos = r_by;
    assign bus.block_valid = r_bvalid;
    assign bus.block_idx   = r_bidx;
    assign bus.sweep_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_maze_block_feeder.sv
`default_nettype none
// ============================================================================
//  Module  : tb_maze_block_feeder
//  Purpose : Directed + randomized sweeps on three tables vs. a trace model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_maze_block_feeder;

    localparam int DWELL = 4;
    localparam int NB    = 16;
    localparam int TL    = 60;
    localparam int OX    = 62;
    localparam int OY    = 108;
    localparam int MARG  = 61;

    localparam logic [2047:0] TBL_A = {{253{8'hFF}}, 8'hFF, 8'h12, 8'h00};
    localparam logic [2047:0] TBL_B = {{240{8'hFF}},
        8'h93, 8'h7C, 8'h2B, 8'h19, 8'h48, 8'h47, 8'h38, 8'h37,
        8'h66, 8'h65, 8'h56, 8'h55, 8'hAE, 8'hA0, 8'h0E, 8'h00};
    localparam logic [2047:0] TBL_C = {{247{8'hFF}},
        8'hFF, 8'h43, 8'h3F, 8'h44, 8'hF0, 8'h34, 8'hB0, 8'h33, 8'h0F};

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        v;
        logic [7:0]  idx;
        logic        done;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] hero_x = '0;
    logic [11:0] hero_y = '0;
    logic [2:0]  en = 3'b000;
    int          sel = 0;
    int          tests = 0;
    int          fails = 0;
    obs_t        prev [3];
    obs_t        exp_q [$];
    obs_t        obs;
    logic [7:0]  tbl [3][NB];

    always #5 clk = ~clk;

    maze_block_feeder_if if_a();
    maze_block_feeder_if if_b();
    maze_block_feeder_if if_c();

    assign if_a.enable = en[0];
    assign if_b.enable = en[1];
    assign if_c.enable = en[2];
    assign if_a.hero_x_pos = hero_x;
    assign if_a.hero_y_pos = hero_y;
    assign if_b.hero_x_pos = hero_x;
    assign if_b.hero_y_pos = hero_y;
    assign if_c.hero_x_pos = hero_x;
    assign if_c.hero_y_pos = hero_y;

    maze_block_feeder #(.NUM_BLOCKS(NB), .DWELL_CYCLES(DWELL), .ROM_INIT(TBL_A))
        u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
    maze_block_feeder #(.NUM_BLOCKS(NB), .DWELL_CYCLES(DWELL), .ROM_INIT(TBL_B))
        u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
    maze_block_feeder #(.NUM_BLOCKS(NB), .DWELL_CYCLES(DWELL), .ROM_INIT(TBL_C))
        u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

    always_comb begin
        obs = {if_a.block_x_pos, if_a.block_y_pos, if_a.block_valid, if_a.block_idx, if_a.sweep_done};
        case (sel)
            1: obs = {if_b.block_x_pos, if_b.block_y_pos, if_b.block_valid, if_b.block_idx, if_b.sweep_done};
            2: obs = {if_c.block_x_pos, if_c.block_y_pos, if_c.block_valid, if_c.block_idx, if_c.sweep_done};
            default: ;
        endcase
    end

    task automatic check(input string tag, input int k, input obs_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s step %0d: observed x=%0d y=%0d v=%b idx=%0d done=%b, expected x=%0d y=%0d v=%b idx=%0d done=%b",
                   tag, k, obs.x, obs.y, obs.v, obs.idx, obs.done, exp.x, exp.y, exp.v, exp.idx, exp.done);
        end
    endtask

    // Cycle-by-cycle expected outputs, starting with the first FETCH cycle.
    task automatic build(input int s, input int hx, input int hy, input int n_idle);
        obs_t cur;
        bit   any;
        cur = prev[s];
        any = 1'b0;
        exp_q.delete();
        for (int i = 0; i <= NB; i++) begin
            logic [7:0] e;
            int col, row, px, py, dx, dy;
            repeat (3) exp_q.push_back(cur);
            e = 8'hFF;
            if (i < NB) e = tbl[s][i];
            if (e == 8'hFF || i == NB) begin
                if (!any) cur = '0;
                cur.done = 1'b1;
                exp_q.push_back(cur);
                cur.done = 1'b0;
                break;
            end
            col = int'(e[3:0]);
            row = int'(e[7:4]);
            px  = OX + col * TL;
            py  = OY + row * TL;
            dx  = (hx > px) ? hx - px : px - hx;
            dy  = (hy > py) ? hy - py : py - hy;
            if (col <= 14 && row <= 10 && dx <= MARG && dy <= MARG) begin
                cur.x   = 12'(px);
                cur.y   = 12'(py);
                cur.v   = 1'b1;
                cur.idx = 8'(i);
                any     = 1'b1;
                repeat (DWELL) exp_q.push_back(cur);
            end
        end
        prev[s] = cur;
        repeat (n_idle) exp_q.push_back(cur);
    endtask

    task automatic sweep(input string tag, input int s, input logic [11:0] hx, input logic [11:0] hy,
                         input bit move, input int n_idle);
        sel    = s;
        hero_x = hx;
        hero_y = hy;
        en     = 3'(1 << s);
        build(s, int'(hx), int'(hy), n_idle);
        @(posedge clk);
        @(negedge clk);
        en = 3'b000;
        if (move) begin
            hero_x = 12'($urandom_range(0, 4095));
            hero_y = 12'($urandom_range(0, 4095));
        end
        foreach (exp_q[k]) begin
            check(tag, k, exp_q[k]);
            if (k < exp_q.size() - 1) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < NB; i++) begin
            tbl[0][i] = TBL_A[8*i +: 8];
            tbl[1][i] = TBL_B[8*i +: 8];
            tbl[2][i] = TBL_C[8*i +: 8];
        end
        for (int s = 0; s < 3; s++) prev[s] = '0;

        // Reset held with enable high: everything idle at zero.
        en = 3'b001;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("reset", s, '0);
        end
        @(negedge clk);
        rst = 1'b0;
        sweep("two_near", 0, 12'd122, 12'd108, 1'b0, 0);
        sweep("none_near", 0, 12'd902, 12'd708, 1'b0, 2);

        // Full table without sentinel, back-to-back sweeps.
        sweep("full_tbl_1", 1, 12'd62, 12'd108, 1'b0, 0);
        sweep("full_tbl_2", 1, 12'd302, 12'd408, 1'b0, 2);

        // Out-of-range entries must never be presented.
        sweep("oor_cluster", 2, 12'd242, 12'd288, 1'b0, 1);
        sweep("oor_col15", 2, 12'd962, 12'd108, 1'b0, 1);

        sweep("hero_moves", 0, 12'd122, 12'd108, 1'b1, 4);

        // Asynchronous reset while block 0 is being presented.
        sel    = 0;
        hero_x = 12'd62;
        hero_y = 12'd108;
        en     = 3'b001;
        build(0, 62, 108, 0);
        @(posedge clk);
        @(negedge clk);
        en = 3'b000;
        repeat (4) @(negedge clk);
        check("pre_reset", 4, exp_q[4]);
        #2 rst = 1'b1;
        #1 check("async_reset", 0, '0);
        for (int s = 0; s < 3; s++) prev[s] = '0;
        @(negedge clk);
        rst = 1'b0;
        sweep("after_reset", 0, 12'd62, 12'd108, 1'b0, 1);

        for (int r = 0; r < 24; r++) begin
            int         s, hx, hy;
            logic [7:0] e;
            s = int'($urandom_range(0, 2));
            if ($urandom_range(0, 2) != 0) begin
                e  = tbl[s][$urandom_range(0, NB - 1)];
                hx = OX + int'(e[3:0]) * TL + int'($urandom_range(0, 140)) - 70;
                hy = OY + int'(e[7:4]) * TL + int'($urandom_range(0, 140)) - 70;
                if (hx < 0) hx = 0;
                if (hy < 0) hy = 0;
            end else begin
                hx = int'($urandom_range(0, 1100));
                hy = int'($urandom_range(0, 900));
            end
            sweep("random", s, 12'(hx), 12'(hy), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
